pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central hazard controller for the 5-stage RV32I pipeline. Merges per-stage stall requests into the
//  shared stall bus consumed by pc_reg/if_id/id_ex/ex_mem/mem_wb, and sequences branch redirects:
//  PC redirect plus flush of if_id and id_ex, deferring both while the front end is frozen.
//  Also keeps a saturating stall-cycle counter for performance debug.
// PARAMETERS
//  STALL_W   6     stall bus width; bit 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb (`StallBus)
//  ADDR_W    32    PC / branch target width (`RegBus)
//  CNT_W     16    stall-cycle counter width
// PORTS
//  clk            in   1        clock
//  rst            in   1        reset; asynchronous, active-high
//  req_if         in   1        IF cannot deliver an instruction (icache miss / bus busy)
//  req_id         in   1        ID load-use hazard
//  req_mem        in   1        MEM access in progress (dcache / bus busy)
//  br_taken_ex    in   1        EX resolved a taken branch/jump this cycle
//  br_target_ex   in   ADDR_W   redirect target, valid with br_taken_ex
//  clr_cnt        in   1        synchronous clear of stall_cycles
//  stall_out      out  STALL_W  stall bus to all pipeline registers
//  flush_out      out  2        bit0: bubble if_id; bit1: bubble id_ex (override stall for that register)
//  redir_valid    out  1        pc_reg loads redir_addr this edge
//  redir_addr     out  ADDR_W   redirect target
//  stall_cycles   out  CNT_W    saturating count of cycles with stall_out[0]=1
// BEHAVIOUR
//  Reset: FSM=IDLE, target reg=0, stall_cycles=0; stall_out=0, flush_out=0, redir_valid=0, redir_addr=0.
//  Stall encode (combinational, priority high->low):
//   req_mem -> 6'b011111; else req_id -> 6'b000111; else req_if -> 6'b000011; else 6'b000000.
//  stall_out[5] is never asserted (WB is always allowed to retire).
//  Branch acceptance: br_taken_ex counts only when stall_out[3]=0 (EX advances). Otherwise ignored.
//  FSM states: IDLE, PEND.
//   IDLE, accepted branch, stall_out[0]=0: same cycle redir_valid=1, redir_addr=br_target_ex,
//     flush_out=2'b11; stay IDLE. Zero-cycle latency (combinational path br_taken_ex -> redir/flush).
//   IDLE, accepted branch, stall_out[0]=1: latch target, flush_out[1]=1 this cycle (kill ID instr entering EX);
//     -> PEND. redir_valid stays 0.
//   PEND: redir_addr=latched target. When stall_out[0]=0: redir_valid=1, flush_out=2'b11, -> IDLE.
//     While stall_out[0]=1: hold, outputs 0 except redir_addr.
//   PEND ignores br_taken_ex (wrong-path instrs already flushed; none can reach EX).
//  Flush vs stall: flush_out bits win over stall for the targeted register; stall_out is not modified by flush.
//  Simultaneous req_mem and accepted branch: impossible by encode (stall_out[3]=1 blocks acceptance).
//  Counter: increments each cycle stall_out[0]=1; saturates at all-ones; clr_cnt has priority over increment.
//  Reset asserted mid-PEND: pending redirect discarded, FSM -> IDLE immediately (async).
// STRUCTURE
//  define.v: `StallBus, stage index macros (STG_PC..STG_WB), stall encodings STALL_MEM/ID/IF/NONE, `RegBus.
//  Sub-module: stall_encode (pure combinational priority encoder, req_* -> stall vector), instanced once;
//  FSM, target register and counter live in pipe_ctrl.
// TESTING
//  1 reset mid-stream: assert rst while PEND -> next sampled outputs all 0, FSM IDLE, stall_cycles=0.
//  2 priority: req_if=1, req_id=1, req_mem=1 same cycle -> stall_out=6'b011111; drop req_mem -> 6'b000111.
//  3 clean branch: no reqs, br_taken_ex=1, target=32'h0000_1040 -> same cycle redir_valid=1,
//    redir_addr=32'h1040, flush_out=2'b11; next cycle all 0.
//  4 deferred branch: req_if=1 with br_taken_ex=1 (target 32'h200) -> flush_out=2'b10, no redirect;
//    hold req_if 3 cycles then drop -> on drop cycle redir_valid=1, redir_addr=32'h200, flush_out=2'b11.
//  5 blocked branch: req_mem=1 with br_taken_ex=1 -> no redirect, no flush, FSM stays IDLE.
//  6 counter: hold req_if 70000 cycles -> stall_cycles=16'hFFFF; clr_cnt with req_if=1 -> 0 next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared stage indices and controller state type for pipe_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_stall_encode.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_stall_encode
//  Description : Priority encoder from per-stage stall requests to stall bus.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl_stall_encode
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = 6
) (
    input  logic               i_req_if,
    input  logic               i_req_id,
    input  logic               i_req_mem,
    output logic [STALL_W-1:0] o_stall
);

    // Each request freezes its own stage and everything upstream; WB never stalls.
    always_comb begin
        o_stall = '0;
        if (i_req_mem) begin
            o_stall[STG_MEM:STG_PC] = '1;
        end else if (i_req_id) begin
            o_stall[STG_ID:STG_PC] = '1;
        end else if (i_req_if) begin
            o_stall[STG_IF:STG_PC] = '1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline hazard controller: stall bus, branch redirect/flush
//                sequencing and saturating stall-cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req_if,
    input  logic               i_req_id,
    input  logic               i_req_mem,
    input  logic               i_br_taken_ex,
    input  logic [ADDR_W-1:0]  i_br_target_ex,
    input  logic               i_clr_cnt,
    output logic [STALL_W-1:0] o_stall_out,
    output logic [1:0]         o_flush_out,
    output logic               o_redir_valid,
    output logic [ADDR_W-1:0]  o_redir_addr,
    output logic [CNT_W-1:0]   o_stall_cycles
);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [ADDR_W-1:0] r_tgt;
    logic              w_load_tgt;
    logic              w_accept;
    logic              w_frozen;
    logic [STALL_W-1:0] w_stall;
    logic [CNT_W-1:0]  r_cnt;

    pipe_ctrl_stall_encode #(
        .STALL_W (STALL_W)
    ) u_stall_encode (
        .i_req_if  (i_req_if),
        .i_req_id  (i_req_id),
        .i_req_mem (i_req_mem),
        .o_stall   (w_stall)
    );

    assign o_stall_out    = w_stall;
    assign w_frozen       = w_stall[STG_PC];
    assign w_accept       = i_br_taken_ex && !w_stall[STG_EX];
    assign o_stall_cycles = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_tgt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_tgt) begin
                r_tgt <= i_br_target_ex;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_tgt    = 1'b0;
        o_flush_out   = 2'b00;
        o_redir_valid = 1'b0;
        o_redir_addr  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!w_frozen) begin
                        o_redir_valid = 1'b1;
                        o_redir_addr  = i_br_target_ex;
                        o_flush_out   = 2'b11;
                    end else begin
                        // Front end frozen: kill the ID instr now, redirect later.
                        w_load_tgt  = 1'b1;
                        o_flush_out = 2'b10;
                        w_state_nxt = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                o_redir_addr = r_tgt;
                if (!w_frozen) begin
                    o_redir_valid = 1'b1;
                    o_flush_out   = 2'b11;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr_cnt) begin
            r_cnt <= '0;
        end else if (w_frozen && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Self-checking bench for pipe_ctrl with a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        r_req_if, r_req_id, r_req_mem, r_br, r_clr;
    logic [31:0] r_tgt_in;
    logic [5:0]  w_stall;
    logic [1:0]  w_flush;
    logic        w_rvalid;
    logic [31:0] w_raddr;
    logic [15:0] w_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: a pending redirect flag/target and an integer stall count.
    bit          m_pend;
    logic [31:0] m_tgt;
    int          m_cnt;

    pipe_ctrl #(
        .STALL_W (6),
        .ADDR_W  (32),
        .CNT_W   (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req_if       (r_req_if),
        .i_req_id       (r_req_id),
        .i_req_mem      (r_req_mem),
        .i_br_taken_ex  (r_br),
        .i_br_target_ex (r_tgt_in),
        .i_clr_cnt      (r_clr),
        .o_stall_out    (w_stall),
        .o_flush_out    (w_flush),
        .o_redir_valid  (w_rvalid),
        .o_redir_addr   (w_raddr),
        .o_stall_cycles (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // One cycle: drive at negedge, check combinational outputs, advance model at posedge.
    task automatic step(input bit mem, input bit id, input bit fi, input bit br,
                        input logic [31:0] tgt, input bit clr, input bit do_chk);
        int          lvl;
        logic [5:0]  e_stall;
        logic [1:0]  e_flush;
        logic        e_valid;
        logic [31:0] e_addr;
        bit          frozen;
        @(negedge clk);
        r_req_mem = mem; r_req_id = id; r_req_if = fi; r_br = br; r_tgt_in = tgt; r_clr = clr;
        #1;
        lvl     = mem ? 5 : id ? 3 : fi ? 2 : 0;
        e_stall = 6'((1 << lvl) - 1);
        frozen  = (lvl > 0);
        e_flush = 2'b00; e_valid = 1'b0; e_addr = 32'h0;
        if (m_pend) begin
            e_addr = m_tgt;
            if (!frozen) begin
                e_valid = 1'b1; e_flush = 2'b11; m_pend = 1'b0;
            end
        end else if (br && lvl < 4) begin
            if (!frozen) begin
                e_valid = 1'b1; e_addr = tgt; e_flush = 2'b11;
            end else begin
                e_flush = 2'b10; m_pend = 1'b1; m_tgt = tgt;
            end
        end
        if (do_chk) begin
            chk("stall_out",    32'(w_stall),  32'(e_stall));
            chk("flush_out",    32'(w_flush),  32'(e_flush));
            chk("redir_valid",  32'(w_rvalid), 32'(e_valid));
            chk("redir_addr",   w_raddr,       e_addr);
            chk("stall_cycles", 32'(w_cnt),    32'(m_cnt));
        end
        if (clr)         m_cnt = 0;
        else if (frozen) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 32'h0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        r_req_if = 0; r_req_id = 0; r_req_mem = 0; r_br = 0; r_clr = 0; r_tgt_in = '0;
        m_pend = 0; m_tgt = '0; m_cnt = 0;
        #2;
        chk("rst_stall",  32'(w_stall),  32'h0);
        chk("rst_flush",  32'(w_flush),  32'h0);
        chk("rst_rvalid", 32'(w_rvalid), 32'h0);
        chk("rst_raddr",  w_raddr,       32'h0);
        chk("rst_cnt",    32'(w_cnt),    32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Priority: all requests, then drop req_mem.
        step(1, 1, 1, 0, 32'h0, 0, 1);
        chk("prio_all", 32'(w_stall), 32'h1F);
        step(0, 1, 1, 0, 32'h0, 0, 1);
        chk("prio_id", 32'(w_stall), 32'h07);

        // Clean branch: zero-latency redirect, quiet next cycle.
        step(0, 0, 0, 1, 32'h0000_1040, 0, 1);
        chk("clean_rvalid", 32'(w_rvalid), 32'h1);
        chk("clean_raddr",  w_raddr,       32'h1040);
        chk("clean_flush",  32'(w_flush),  32'h3);
        idle_step();
        chk("clean_after", 32'(w_rvalid), 32'h0);

        // Deferred branch under req_if, redirect on the release cycle.
        step(0, 0, 1, 1, 32'h200, 0, 1);
        chk("defer_flush",  32'(w_flush),  32'h2);
        chk("defer_rvalid", 32'(w_rvalid), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 32'hDEAD_0000, 0, 1);
        step(0, 0, 0, 0, 32'h0, 0, 1);
        chk("defer_rvalid2", 32'(w_rvalid), 32'h1);
        chk("defer_raddr",   w_raddr,       32'h200);
        chk("defer_flush2",  32'(w_flush),  32'h3);
        idle_step();

        // Blocked branch under req_mem, then no leftover redirect.
        step(1, 0, 0, 1, 32'h300, 0, 1);
        chk("blk_flush",  32'(w_flush),  32'h0);
        chk("blk_rvalid", 32'(w_rvalid), 32'h0);
        idle_step();
        chk("blk_after", 32'(w_rvalid), 32'h0);

        // Reset while a redirect is pending.
        step(0, 1, 0, 1, 32'h400, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        r_req_if = 0; r_req_id = 0; r_req_mem = 0; r_br = 0; r_clr = 0;
        #1;
        m_pend = 0; m_cnt = 0;
        chk("mid_rst_rvalid", 32'(w_rvalid), 32'h0);
        chk("mid_rst_raddr",  w_raddr,       32'h0);
        chk("mid_rst_flush",  32'(w_flush),  32'h0);
        chk("mid_rst_cnt",    32'(w_cnt),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_step();
        chk("post_rst_idle", 32'(w_rvalid), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 12, $urandom_range(99) < 18, $urandom_range(99) < 30,
                 $urandom_range(99) < 35, $urandom, $urandom_range(99) < 3, 1);
        end
        idle_step();

        // Counter saturation and clear.
        for (int i = 0; i < 66000; i++) step(0, 0, 1, 0, 32'h0, 0, 0);
        step(0, 0, 1, 0, 32'h0, 0, 1);
        chk("cnt_sat", 32'(w_cnt), 32'hFFFF);
        step(0, 0, 1, 0, 32'h0, 1, 1);
        step(0, 0, 0, 0, 32'h0, 0, 1);
        chk("cnt_clr", 32'(w_cnt), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
